// File: rtl/tsv_arb_pkg.sv
// Shared definitions for the TSV bus arbiter.
//   arb_state_t : arbiter FSM states (also exported on the debug port)
//   BEAF_TAG    : tag carried in the upper half of self-test frame beats
//   idw()       : width of a layer index for a given layer count
package tsv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    localparam logic [15:0] BEAF_TAG = 16'hBEAF;

    // A single-layer stack would give clog2 = 0; keep at least one bit.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tsv_bus_arbiter_rr_pick.sv
// Round-robin winner selection (purely combinational).
//   req    : per-layer request vector
//   rr_ptr : layer index that has the highest priority this round
//   any    : at least one request is set
//   winner : first requesting layer scanning rr_ptr, rr_ptr+1, ... mod N_LAYERS
module rr_pick
    import tsv_arb_pkg::*;
#(
    parameter int N_LAYERS = 4,
    parameter int IDW      = idw(N_LAYERS)
) (
    input  logic [N_LAYERS-1:0] req,
    input  logic [IDW-1:0]      rr_ptr,
    output logic                any,
    output logic [IDW-1:0]      winner
);

    int             idx;
    logic [IDW-1:0] idx_l;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        idx_l  = '0;
        // Walk the ring starting at rr_ptr; the first hit wins.
        for (int k = 0; k < N_LAYERS; k++) begin
            idx   = (int'(rr_ptr) + k) % N_LAYERS;
            idx_l = IDW'(idx);
            if (!any && req[idx_l]) begin
                any    = 1'b1;
                winner = idx_l;
            end
        end
    end

endmodule

// File: rtl/tsv_bus_arbiter.sv
// Round-robin arbiter for the shared inter-layer TSV data bus.
// One layer owns the bus at a time; its beats are forwarded with one cycle
// of latency. Beat-count and watchdog limits force a release so a hung
// layer cannot starve the stack.
//
// Beat handshake: a beat transfers on every XFER cycle in which the owner's
// valid is high; there is no backpressure (no ready), so the owner must hold
// data/last stable only for that cycle. last is ignored unless valid is high.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req          : per-layer level request
//   valid, last  : per-layer beat valid and last-beat flag (owner's only used)
//   data_in      : layer i beat on [i*DW +: DW]
//   gnt          : registered one-hot grant
//   bus_data     : registered bus beat (holds outside XFER)
//   bus_valid    : registered bus beat valid
//   busy         : high in GRANT/XFER/GAP
//   timeout_err  : 1-cycle pulse when the watchdog revokes a grant
//   overrun_err  : 1-cycle pulse when MAX_BEATS is reached without last
//   err_layer    : owner at the most recent error
//   state_dbg    : current FSM state
module tsv_bus_arbiter
    import tsv_arb_pkg::*;
#(
    parameter int  N_LAYERS  = 4,
    parameter int  DW        = 32,
    parameter int  MAX_BEATS = 8,
    parameter int  TIMEOUT   = 35,
    localparam int IDW       = idw(N_LAYERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_LAYERS-1:0]    req,
    input  logic [N_LAYERS-1:0]    valid,
    input  logic [N_LAYERS-1:0]    last,
    input  logic [N_LAYERS*DW-1:0] data_in,
    output logic [N_LAYERS-1:0]    gnt,
    output logic [DW-1:0]          bus_data,
    output logic                   bus_valid,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   overrun_err,
    output logic [IDW-1:0]         err_layer,
    output arb_state_t             state_dbg
);

    localparam int                  BW        = $clog2(MAX_BEATS + 1);
    localparam int                  WW        = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0]       BEAT_LAST = BW'(MAX_BEATS - 1);
    localparam logic [WW-1:0]       WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [IDW-1:0]      LAST_ID   = IDW'(N_LAYERS - 1);
    localparam logic [N_LAYERS-1:0] ONE_HOT0  = N_LAYERS'(1);

    arb_state_t     state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] rr_ptr;
    logic [BW-1:0]  beat_cnt;
    logic [WW-1:0]  wd_cnt;

    logic           pick_any;
    logic [IDW-1:0] pick_winner;

    logic [DW-1:0]  lane [N_LAYERS];
    logic [DW-1:0]  own_data;
    logic           own_valid;
    logic           own_last;
    logic           own_req;

    logic           exit_now;
    logic           ovr_hit;
    logic           to_hit;

    assign state_dbg = state;

    for (genvar i = 0; i < N_LAYERS; i++) begin : g_lane
        assign lane[i] = data_in[i*DW +: DW];
    end

    assign own_data  = lane[owner];
    assign own_valid = valid[owner];
    assign own_last  = last[owner];
    assign own_req   = req[owner];

    rr_pick #(
        .N_LAYERS (N_LAYERS),
        .IDW      (IDW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // XFER exit decode. The if/else chain fixes precedence: a dropped request
    // aborts silently, a last beat always ends cleanly (even when it lands on
    // the final watchdog cycle), then overrun, then watchdog.
    always_comb begin
        exit_now = 1'b0;
        ovr_hit  = 1'b0;
        to_hit   = 1'b0;
        if (!own_req) begin
            exit_now = 1'b1;
        end else if (own_valid && own_last) begin
            exit_now = 1'b1;
        end else if (own_valid && (beat_cnt == BEAT_LAST)) begin
            exit_now = 1'b1;
            ovr_hit  = 1'b1;
        end else if (wd_cnt == WD_LAST) begin
            exit_now = 1'b1;
            to_hit   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            wd_cnt      <= '0;
            gnt         <= '0;
            bus_data    <= '0;
            bus_valid   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            err_layer   <= '0;
        end else begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner <= pick_winner;
                        gnt   <= ONE_HOT0 << pick_winner;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    beat_cnt <= '0;
                    wd_cnt   <= '0;
                    state    <= XFER;
                end
                XFER: begin
                    // The beat sampled on the exit edge is still forwarded.
                    bus_data  <= own_data;
                    bus_valid <= own_valid;
                    if (own_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    wd_cnt <= wd_cnt + 1'b1;
                    if (exit_now) begin
                        gnt   <= '0;
                        state <= GAP;
                        if (ovr_hit) begin
                            overrun_err <= 1'b1;
                            err_layer   <= owner;
                        end
                        if (to_hit) begin
                            timeout_err <= 1'b1;
                            err_layer   <= owner;
                        end
                    end
                end
                GAP: begin
                    bus_valid <= 1'b0;
                    rr_ptr    <= (owner == LAST_ID) ? '0 : owner + 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tsv_bus_arbiter.sv
`timescale 1ns/1ps
module tb_tsv_bus_arbiter;
    import tsv_arb_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int IDW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req;
    logic [N-1:0]    valid;
    logic [N-1:0]    last;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   bus_data;
    logic            bus_valid;
    logic            busy;
    logic            timeout_err;
    logic            overrun_err;
    logic [IDW-1:0]  err_layer;
    arb_state_t      state_dbg;

    tsv_bus_arbiter #(
        .N_LAYERS  (N),
        .DW        (DW),
        .MAX_BEATS (8),
        .TIMEOUT   (35)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .valid       (valid),
        .last        (last),
        .data_in     (data_in),
        .gnt         (gnt),
        .bus_data    (bus_data),
        .bus_valid   (bus_valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err),
        .err_layer   (err_layer),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [DW:0]    exp_q[$];   // {frame_end_mark, beat}
    logic [IDW-1:0] gnt_q[$];   // expected grant order
    int checks   = 0;
    int failures = 0;
    int ovr_cnt  = 0;
    int to_cnt   = 0;
    int low_cnt  = 0;
    bit gap_armed = 1'b0;
    logic [N-1:0]  prev_gnt = '0;
    logic [DW:0]   mon_e;
    logic [N-1:0]  mon_oh;
    logic [IDW-1:0] mon_w;
    logic [DW-1:0] last_d = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_gnt = '0;
            low_cnt  = 0;
        end else begin
            check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
            if (bus_valid) begin
                if (gap_armed) begin
                    check("frame_gap_ge3", 64'(low_cnt >= 3), 64'd1);
                    gap_armed = 1'b0;
                end
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("bus_data", 64'(bus_data), 64'(mon_e[DW-1:0]));
                    if (mon_e[DW]) gap_armed = 1'b1;
                end
                low_cnt = 0;
            end else begin
                low_cnt++;
            end
            if (overrun_err) ovr_cnt++;
            if (timeout_err) to_cnt++;
            if (gnt != '0 && prev_gnt == '0) begin
                check("gnt_expected", 64'(gnt_q.size() != 0), 64'd1);
                if (gnt_q.size() != 0) begin
                    mon_w  = gnt_q.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_w] = 1'b1;
                    check("gnt_order", 64'(gnt), 64'(mon_oh));
                end
            end
            prev_gnt = gnt;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic [IDW-1:0] layer);
        int n;
        n = 0;
        while (gnt[layer] !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("wait_gnt", 64'(gnt[layer]), 64'd1);
    endtask

    // Waits for the grant, skips the GRANT cycle, then drives n back-to-back
    // beats. The final beat carries last when use_last is set.
    task automatic send_frame(input logic [IDW-1:0] layer, input int n,
                              input bit use_last, input bit release_chk);
        logic [DW-1:0] d;
        wait_gnt(layer);
        tick();
        for (int b = 0; b < n; b++) begin
            d = {BEAF_TAG, 16'($urandom_range(0, 65535))};
            data_in[int'(layer)*DW +: DW] = d;
            valid[layer] = 1'b1;
            last[layer]  = use_last && (b == n - 1);
            exp_q.push_back({(b == n - 1), d});
            last_d = d;
            tick();
        end
        valid[layer] = 1'b0;
        last[layer]  = 1'b0;
        if (release_chk) begin
            check("gnt_released", 64'(gnt), 64'd0);
            check("busy_in_gap", 64'(busy), 64'd1);
        end
    endtask

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "bench watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        req     = '0;
        valid   = '0;
        last    = '0;
        data_in = '0;
        for (int i = 0; i < N; i++) data_in[i*DW +: DW] = $urandom;

        // Reset values; request pattern already present at release.
        req = 4'b0110;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_bus_valid", 64'(bus_valid), 64'd0);
        check("rst_bus_data", 64'(bus_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_overrun_err", 64'(overrun_err), 64'd0);
        check("rst_err_layer", 64'(err_layer), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));

        // Test 1: rr_ptr=0, req=0110 -> layer 1 first, then layer 2.
        gnt_q.push_back(2'd1);
        gnt_q.push_back(2'd2);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("t1_gnt_t_plus_1", 64'(gnt), 64'b0010);
        check("t1_busy", 64'(busy), 64'd1);
        send_frame(2'd1, 2, 1'b1, 1'b1);
        req = 4'b0100;
        send_frame(2'd2, 2, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        check("t1_bus_data_hold", 64'(bus_data), 64'(last_d));
        check("t1_bus_valid_idle", 64'(bus_valid), 64'd0);

        // Test 3: layer 3 sends 8 beats without last -> overrun.
        req = 4'b1000;
        gnt_q.push_back(2'd3);
        send_frame(2'd3, 8, 1'b0, 1'b1);
        req = 4'b0000;
        tick();
        check("t3_overrun_pulses", 64'(ovr_cnt), 64'd1);
        check("t3_timeout_pulses", 64'(to_cnt), 64'd0);
        check("t3_err_layer", 64'(err_layer), 64'd3);
        check("t3_bus_data_hold", 64'(bus_data), 64'(last_d));

        // Test 2: all four request; rr_ptr=0 -> order 0,1,2,3,0.
        req = 4'b1111;
        gnt_q.push_back(2'd0);
        gnt_q.push_back(2'd1);
        gnt_q.push_back(2'd2);
        gnt_q.push_back(2'd3);
        gnt_q.push_back(2'd0);
        send_frame(2'd0, 2, 1'b1, 1'b1);
        send_frame(2'd1, 2, 1'b1, 1'b1);
        send_frame(2'd2, 2, 1'b1, 1'b1);
        send_frame(2'd3, 2, 1'b1, 1'b1);
        send_frame(2'd0, 2, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        check("t2_no_errors", 64'(ovr_cnt + to_cnt), 64'd1);

        // Test 4: layer 1 holds req, never valid -> watchdog after 35 XFER cycles.
        req = 4'b0010;
        gnt_q.push_back(2'd1);
        wait_gnt(2'd1);
        begin
            int n;
            n = 0;
            while (gnt[1] === 1'b1 && n < 100) begin
                tick();
                n++;
            end
            // One GRANT cycle plus 35 XFER cycles.
            check("t4_gnt_hold_cycles", 64'(n), 64'd36);
        end
        req = 4'b0000;
        tick();
        check("t4_timeout_pulses", 64'(to_cnt), 64'd1);
        check("t4_overrun_pulses", 64'(ovr_cnt), 64'd1);
        check("t4_err_layer", 64'(err_layer), 64'd1);

        // Test 5: layer 2 drops req after 3 beats; layer 0 then granted.
        req = 4'b0101;
        gnt_q.push_back(2'd2);
        gnt_q.push_back(2'd0);
        send_frame(2'd2, 3, 1'b0, 1'b0);
        req[2] = 1'b0;
        tick();
        check("t5_abort_gnt", 64'(gnt), 64'd0);
        send_frame(2'd0, 2, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        check("t5_no_new_errors", 64'(ovr_cnt + to_cnt), 64'd2);
        check("t5_err_layer_held", 64'(err_layer), 64'd1);

        // Test 6: reset during beat 2 of layer 3; rr_ptr restarts at 0.
        req = 4'b1000;
        gnt_q.push_back(2'd3);
        wait_gnt(2'd3);
        tick();
        data_in[3*DW +: DW] = {BEAF_TAG, 16'h0001};
        exp_q.push_back({1'b1, BEAF_TAG, 16'h0001});
        valid[3] = 1'b1;
        tick();
        data_in[3*DW +: DW] = {BEAF_TAG, 16'h0002};
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_gnt", 64'(gnt), 64'd0);
        check("t6_rst_bus_valid", 64'(bus_valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_state", 64'(state_dbg), 64'(IDLE));
        valid = '0;
        last  = '0;
        req   = 4'b1001;
        gnt_q.push_back(2'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("t6_gnt_after_rst", 64'(gnt), 64'b0001);
        send_frame(2'd0, 1, 1'b1, 1'b1);
        req = 4'b0000;
        repeat (3) tick();

        check("end_exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("end_gnt_q_empty", 64'(gnt_q.size()), 64'd0);
        check("end_overrun_total", 64'(ovr_cnt), 64'd1);
        check("end_timeout_total", 64'(to_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
